// File: rtl/isq_pkg.sv
// Shared issue-queue definitions: dispatch payload layout and the wrap-aware age compare
// used by the issue queue, ROB and flush logic.
package isq_pkg;

    localparam int ISQ_ID_WIDTH   = 7;
    localparam int ISQ_PREG_WIDTH = 6;

    // Dispatch payload layout, LSB first; 248 bits in total
    localparam int ISQ_PL_ID_LSB   = 0;
    localparam int ISQ_PL_PC_LSB   = ISQ_PL_ID_LSB + ISQ_ID_WIDTH;
    localparam int ISQ_PL_PC_W     = 64;
    localparam int ISQ_PL_PRS1_LSB = ISQ_PL_PC_LSB + ISQ_PL_PC_W;
    localparam int ISQ_PL_PRS2_LSB = ISQ_PL_PRS1_LSB + ISQ_PREG_WIDTH;
    localparam int ISQ_PL_PRD_LSB  = ISQ_PL_PRS2_LSB + ISQ_PREG_WIDTH;
    localparam int ISQ_PL_IMM_LSB  = ISQ_PL_PRD_LSB + ISQ_PREG_WIDTH;
    localparam int ISQ_PL_IMM_W    = 64;
    localparam int ISQ_PL_CTRL_LSB = ISQ_PL_IMM_LSB + ISQ_PL_IMM_W;
    localparam int ISQ_PL_CTRL_W   = 95;
    localparam int ISQ_PL_WIDTH    = ISQ_PL_CTRL_LSB + ISQ_PL_CTRL_W;

    // IDs live on a circle: a flipped MSB means the other ID has wrapped past it
    function automatic logic is_older(input logic [ISQ_ID_WIDTH-1:0] a,
                                      input logic [ISQ_ID_WIDTH-1:0] b);
        if (a[ISQ_ID_WIDTH-1] == b[ISQ_ID_WIDTH-1])
            return a[ISQ_ID_WIDTH-2:0] < b[ISQ_ID_WIDTH-2:0];
        else
            return a[ISQ_ID_WIDTH-2:0] > b[ISQ_ID_WIDTH-2:0];
    endfunction

endpackage

// File: rtl/isq_age_select.sv
// Combinational oldest-ready picker: an entry wins when it is older than every other ready entry.
module isq_age_select
    import isq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DEPTH_LOG = 3,
    parameter int ID_WIDTH  = ISQ_ID_WIDTH
) (
    input  logic [DEPTH-1:0]               ready,
    input  logic [DEPTH-1:0][ID_WIDTH-1:0] ids,
    output logic [DEPTH-1:0]               grant,
    output logic [DEPTH_LOG-1:0]           grant_idx,
    output logic                           any_ready
);

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && ready[j] && !is_older(ids[i], ids[j]))
                    grant[i] = 1'b0;
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (grant[i])
                grant_idx = grant_idx | DEPTH_LOG'(i);
    end

    assign any_ready = |ready;

endmodule

// File: rtl/issue_queue_age.sv
// Age-ordered out-of-order issue queue with tag-broadcast wakeup, registered output and ID flush.
// Optional ISQ_PERF_CNT_EN adds issue / full-cycle / flush-kill performance counters.
module issue_queue_age
    import isq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG  = 3,
    parameter int DATA_WIDTH = 248,
    parameter int PREG_WIDTH = 6,
    parameter int ID_WIDTH   = ISQ_ID_WIDTH,
    parameter int WAKE_PORTS = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [ID_WIDTH-1:0]              wr_id,
    input  logic [PREG_WIDTH-1:0]            wr_prs1,
    input  logic [PREG_WIDTH-1:0]            wr_prs2,
    input  logic                             wr_rs1_sleep,
    input  logic                             wr_rs2_sleep,
    input  logic [WAKE_PORTS-1:0]            wake_valid,
    input  logic [WAKE_PORTS*PREG_WIDTH-1:0] wake_preg,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [ID_WIDTH-1:0]              out_id,
    input  logic                             flush_valid,
    input  logic [ID_WIDTH-1:0]              flush_id,
    output logic [DEPTH_LOG:0]               count,
    output logic                             full,
    output logic                             empty
`ifdef ISQ_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_issue_cnt,
    output logic [31:0]                      perf_full_cyc,
    output logic [31:0]                      perf_flush_kill
`endif
);

    logic [DEPTH-1:0]                 valid, sleep1, sleep2;
    logic [DEPTH-1:0][PREG_WIDTH-1:0] prs1, prs2;
    logic [DEPTH-1:0][ID_WIDTH-1:0]   ids;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data;

    logic [DEPTH-1:0]     wake1, wake2, ready, grant, kill, alloc;
    logic                 wr_wake1, wr_wake2;
    logic [DEPTH_LOG-1:0] grant_idx;
    logic                 any_ready, fire, load, out_kill;

    // All wakeup ports are matched in parallel, including against the incoming write
    always_comb begin
        logic [PREG_WIDTH-1:0] tag;
        tag      = '0;
        wake1    = '0;
        wake2    = '0;
        wr_wake1 = 1'b0;
        wr_wake2 = 1'b0;
        for (int k = 0; k < WAKE_PORTS; k++) begin
            tag = wake_preg[k*PREG_WIDTH +: PREG_WIDTH];
            if (wake_valid[k]) begin
                if (wr_prs1 == tag) wr_wake1 = 1'b1;
                if (wr_prs2 == tag) wr_wake2 = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (prs1[i] == tag) wake1[i] = 1'b1;
                    if (prs2[i] == tag) wake2[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        alloc = '0;
        count = '0;
        kill  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
            count   = count + (DEPTH_LOG+1)'(valid[i]);
            kill[i] = flush_valid && !is_older(ids[i], flush_id);
        end
    end

    assign ready     = valid & ~sleep1 & ~sleep2;
    assign out_kill  = flush_valid && !is_older(out_id, flush_id);
    assign full      = (count == (DEPTH_LOG+1)'(DEPTH));
    assign empty     = (count == '0) && !out_valid;
    assign wr_ready  = !full;
    assign fire      = wr_valid && wr_ready && !flush_valid;
    assign load      = (!out_valid || out_ready) && any_ready && !flush_valid;

    isq_age_select #(
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG),
        .ID_WIDTH  (ID_WIDTH)
    ) u_select (
        .ready     (ready),
        .ids       (ids),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_ready (any_ready)
    );

    always_ff @(posedge clock) begin
        if (reset)
            valid <= '0;
        else if (flush_valid)
            valid <= valid & ~kill;
        else
            valid <= (valid & ~(load ? grant : '0)) | (fire ? alloc : '0);
    end

    // Entry contents need no reset; valid alone qualifies them
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (fire && alloc[i]) begin
                ids[i]    <= wr_id;
                data[i]   <= wr_data;
                prs1[i]   <= wr_prs1;
                prs2[i]   <= wr_prs2;
                sleep1[i] <= wr_rs1_sleep && !wr_wake1;
                sleep2[i] <= wr_rs2_sleep && !wr_wake2;
            end else begin
                sleep1[i] <= sleep1[i] && !wake1[i];
                sleep2[i] <= sleep2[i] && !wake2[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (flush_valid) begin
            if (out_kill) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_id    <= '0;
            end
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data[grant_idx];
            out_id    <= ids[grant_idx];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ISQ_PERF_CNT_EN
    logic [31:0] kill_cnt;

    always_comb begin
        kill_cnt = 32'(out_valid && out_kill);
        for (int i = 0; i < DEPTH; i++)
            kill_cnt = kill_cnt + 32'(valid[i] && kill[i]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issue_cnt  <= '0;
            perf_full_cyc   <= '0;
            perf_flush_kill <= '0;
        end else begin
            perf_issue_cnt  <= perf_issue_cnt + 32'(load);
            perf_full_cyc   <= perf_full_cyc + 32'(full);
            perf_flush_kill <= perf_flush_kill + kill_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue_age.sv
// Directed bench for issue_queue_age: reset, latency, wakeup order, same-cycle wake, full, wrap age, flush.
module tb_issue_queue_age;

    logic         clock = 1'b0;
    logic         reset;
    logic         wr_valid, wr_ready;
    logic [247:0] wr_data;
    logic [6:0]   wr_id;
    logic [5:0]   wr_prs1, wr_prs2;
    logic         wr_rs1_sleep, wr_rs2_sleep;
    logic [1:0]   wake_valid;
    logic [11:0]  wake_preg;
    logic         out_valid, out_ready;
    logic [247:0] out_data;
    logic [6:0]   out_id;
    logic         flush_valid;
    logic [6:0]   flush_id;
    logic [3:0]   count;
    logic         full, empty;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    issue_queue_age dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_id        (wr_id),
        .wr_prs1      (wr_prs1),
        .wr_prs2      (wr_prs2),
        .wr_rs1_sleep (wr_rs1_sleep),
        .wr_rs2_sleep (wr_rs2_sleep),
        .wake_valid   (wake_valid),
        .wake_preg    (wake_preg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .flush_valid  (flush_valid),
        .flush_id     (flush_id),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    function automatic logic [247:0] pl(input logic [6:0] id);
        return {31{1'b1, id}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_data = '0; wr_id = '0; wr_prs1 = '0; wr_prs2 = '0;
        wr_rs1_sleep = 0; wr_rs2_sleep = 0; wake_valid = '0; wake_preg = '0;
        flush_valid = 0; flush_id = '0;
    endtask

    task automatic wr(input logic [6:0] id, input logic s1, input logic [5:0] p1,
                      input logic s2, input logic [5:0] p2);
        wr_valid = 1; wr_id = id; wr_data = pl(id);
        wr_rs1_sleep = s1; wr_prs1 = p1; wr_rs2_sleep = s2; wr_prs2 = p2;
        tick();
        wr_valid = 0; wr_rs1_sleep = 0; wr_rs2_sleep = 0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1;
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0d exp=0", out_valid); else passes++;
        checks++; if (count !== 4'd0) $display("FAIL rst_count got=%0d exp=0", count); else passes++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready got=%0d exp=1", wr_ready); else passes++;
        checks++; if (empty !== 1'b1) $display("FAIL rst_empty got=%0d exp=1", empty); else passes++;
        checks++; if (full !== 1'b0) $display("FAIL rst_full got=%0d exp=0", full); else passes++;
        checks++; if (out_id !== 7'h00 || out_data !== '0) $display("FAIL rst_out_reg got=%0h exp=0", out_id); else passes++;
    endtask

    task automatic test_basic();
        out_ready = 1;
        wr(7'h05, 0, 6'd0, 0, 6'd0);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_n1_valid got=%0d exp=0", out_valid); else passes++;
        checks++; if (count !== 4'd1) $display("FAIL basic_n1_count got=%0d exp=1", count); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 7'h05) $display("FAIL basic_n2 got=%0d/%0h exp=1/5", out_valid, out_id); else passes++;
        checks++; if (out_data !== pl(7'h05)) $display("FAIL basic_data got=%0h exp=%0h", out_data, pl(7'h05)); else passes++;
        checks++; if (count !== 4'd0) $display("FAIL basic_count_after got=%0d exp=0", count); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1) $display("FAIL basic_drain got=%0d/%0d exp=0/1", out_valid, empty); else passes++;
    endtask

    task automatic test_wake_order();
        logic [6:0] exp_id;
        out_ready = 1;
        wr(7'h03, 1, 6'd10, 0, 6'd0);
        wr(7'h04, 1, 6'd10, 0, 6'd0);
        wr(7'h05, 1, 6'd10, 0, 6'd0);
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 4'd3) $display("FAIL wake_asleep got=%0d/%0d exp=0/3", out_valid, count); else passes++;
        wake_valid = 2'b10; wake_preg = {6'd10, 6'd0};
        tick();
        wake_valid = '0; wake_preg = '0;
        checks++; if (out_valid !== 1'b0) $display("FAIL wake_no_bypass got=%0d exp=0", out_valid); else passes++;
        for (int n = 0; n < 3; n++) begin
            tick();
            exp_id = 7'h03 + 7'(n);
            checks++; if (out_valid !== 1'b1 || out_id !== exp_id) $display("FAIL wake_order%0d got=%0d/%0h exp=1/%0h", n, out_valid, out_id, exp_id); else passes++;
        end
        tick();
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1) $display("FAIL wake_drain got=%0d/%0d exp=0/1", out_valid, empty); else passes++;
    endtask

    task automatic test_same_cycle_wake();
        out_ready = 1;
        wake_valid = 2'b01; wake_preg = {6'd0, 6'd7};
        wr(7'h08, 0, 6'd0, 1, 6'd7);
        wake_valid = '0; wake_preg = '0;
        checks++; if (out_valid !== 1'b0) $display("FAIL scw_n1 got=%0d exp=0", out_valid); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 7'h08) $display("FAIL scw_n2 got=%0d/%0h exp=1/8", out_valid, out_id); else passes++;
        tick();
    endtask

    task automatic test_full();
        logic [6:0] exp_id;
        out_ready = 0;
        for (int n = 0; n < 9; n++) wr(7'(16 + n), 0, 6'd0, 0, 6'd0);
        checks++; if (full !== 1'b1 || wr_ready !== 1'b0) $display("FAIL full_flag got=%0d/%0d exp=1/0", full, wr_ready); else passes++;
        checks++; if (count !== 4'd8) $display("FAIL full_count got=%0d exp=8", count); else passes++;
        wr_valid = 1; wr_id = 7'd25; wr_data = pl(7'd25);
        tick(); tick();
        wr_valid = 0;
        checks++; if (out_id !== 7'd16 || out_data !== pl(7'd16) || count !== 4'd8) $display("FAIL full_hold got=%0h/%0d exp=10/8", out_id, count); else passes++;
        out_ready = 1;
        tick();
        checks++; if (out_id !== 7'd17 || count !== 4'd7 || wr_ready !== 1'b1) $display("FAIL full_release got=%0h/%0d/%0d exp=11/7/1", out_id, count, wr_ready); else passes++;
        for (int n = 18; n <= 24; n++) begin
            tick();
            exp_id = 7'(n);
            checks++; if (out_valid !== 1'b1 || out_id !== exp_id) $display("FAIL full_drain got=%0d/%0h exp=1/%0h", out_valid, out_id, exp_id); else passes++;
        end
        tick();
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1) $display("FAIL full_empty got=%0d/%0d exp=0/1", out_valid, empty); else passes++;
    endtask

    task automatic test_wrap();
        logic [6:0] exp_ids [3];
        exp_ids[0] = 7'h7E; exp_ids[1] = 7'h7F; exp_ids[2] = 7'h00;
        out_ready = 1;
        wr(7'h00, 1, 6'd20, 0, 6'd0);
        wr(7'h7F, 1, 6'd20, 0, 6'd0);
        wr(7'h7E, 1, 6'd20, 0, 6'd0);
        wake_valid = 2'b01; wake_preg = {6'd0, 6'd20};
        tick();
        wake_valid = '0; wake_preg = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_id !== exp_ids[n]) $display("FAIL wrap_order%0d got=%0d/%0h exp=1/%0h", n, out_valid, out_id, exp_ids[n]); else passes++;
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0;
        wr(7'h05, 0, 6'd0, 0, 6'd0);
        wr(7'h02, 0, 6'd0, 0, 6'd0);
        wr(7'h04, 0, 6'd0, 0, 6'd0);
        wr(7'h06, 0, 6'd0, 0, 6'd0);
        checks++; if (out_id !== 7'h05 || count !== 4'd3) $display("FAIL flush_setup got=%0h/%0d exp=5/3", out_id, count); else passes++;
        flush_valid = 1; flush_id = 7'h04;
        wr_valid = 1; wr_id = 7'h09; wr_data = pl(7'h09);
        out_ready = 1;
        tick();
        idle();
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_out got=%0d exp=0", out_valid); else passes++;
        checks++; if (count !== 4'd1) $display("FAIL flush_count got=%0d exp=1", count); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 7'h02) $display("FAIL flush_survivor got=%0d/%0h exp=1/2", out_valid, out_id); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) $display("FAIL flush_drain got=%0d/%0d exp=0/0", out_valid, count); else passes++;
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        wr(7'h28, 0, 6'd0, 0, 6'd0);
        wr(7'h29, 0, 6'd0, 0, 6'd0);
        reset = 1;
        tick();
        reset = 0;
        checks++; if (out_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) $display("FAIL rst_mid got=%0d/%0d exp=0/0", out_valid, count); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_wake_order();
        test_same_cycle_wake();
        test_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
